// File: rtl/spi_reg_master.sv
// SPI mode-0 master: serialises one 1..MAX_BITS frame, MSB-first, per valid/ready handshake.
// Define RBZ_SPIM_VBLANK_SYNC_EN to hold each accepted frame until i_vblank is sampled high.

module spi_reg_master #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned GUARD    = 2,
   parameter int unsigned MAX_BITS = 48
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [5:0]  i_nbits,
   input  logic [47:0] i_data,
   input  logic        i_vblank,
   output logic        o_csb,
   output logic        o_sclk,
   output logic        o_mosi,
   output logic        o_done
);

   localparam int unsigned   TW          = 16;
   localparam logic [TW-1:0] LP_GUARD_LD = TW'(GUARD - 1);
   localparam logic [TW-1:0] LP_DIV_LD   = TW'(CLK_DIV - 1);
   localparam logic [5:0]    LP_MAX_BITS = 6'(MAX_BITS);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEAD  = 3'd1;
   localparam logic [2:0] S_LOW   = 3'd2;
   localparam logic [2:0] S_HIGH  = 3'd3;
   localparam logic [2:0] S_TRAIL = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;
`ifdef RBZ_SPIM_VBLANK_SYNC_EN
   localparam logic [2:0] S_WAIT_VB = 3'd6;
`endif

   logic [2:0]    r_state, w_state;
   logic [TW-1:0] r_tmr, w_tmr;
   logic [5:0]    r_bits, w_bits;
   logic [47:0]   r_shift, w_shift;
   logic          r_csb, w_csb;
   logic          r_sclk, w_sclk;
   logic          r_mosi, w_mosi;
   logic          r_done, w_done;
   logic          r_ready, w_ready;

   logic [5:0]    w_nbits;
   logic [47:0]   w_aligned;
   logic          w_tmr_zero;

`ifndef RBZ_SPIM_VBLANK_SYNC_EN
   logic          w_unused_vblank;
   assign w_unused_vblank = i_vblank;
`endif

   // Frame is left-aligned so the bit on the wire is always r_shift[47].
   assign w_nbits    = (i_nbits > LP_MAX_BITS) ? LP_MAX_BITS : i_nbits;
   assign w_aligned  = i_data << (6'd48 - w_nbits);
   assign w_tmr_zero = (r_tmr == '0);

   assign o_ready = r_ready & i_reset_n;
   assign o_csb   = r_csb;
   assign o_sclk  = r_sclk;
   assign o_mosi  = r_mosi;
   assign o_done  = r_done;

   always_comb begin
      w_state = r_state;
      w_tmr   = w_tmr_zero ? '0 : r_tmr - TW'(1);
      w_bits  = r_bits;
      w_shift = r_shift;
      w_csb   = r_csb;
      w_sclk  = r_sclk;
      w_mosi  = r_mosi;
      w_done  = 1'b0;
      w_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (i_valid && o_ready) begin
               w_ready = 1'b0;
               w_shift = w_aligned;
               w_bits  = w_nbits;
               if (w_nbits == 6'd0) begin
                  w_state = S_GAP;
                  w_tmr   = LP_GUARD_LD;
               end else begin
`ifdef RBZ_SPIM_VBLANK_SYNC_EN
                  w_state = S_WAIT_VB;
`else
                  w_state = S_LEAD;
                  w_tmr   = LP_GUARD_LD;
                  w_csb   = 1'b0;
                  w_mosi  = w_aligned[47];
`endif
               end
            end
         end
`ifdef RBZ_SPIM_VBLANK_SYNC_EN
         S_WAIT_VB: begin
            if (i_vblank) begin
               w_state = S_LEAD;
               w_tmr   = LP_GUARD_LD;
               w_csb   = 1'b0;
               w_mosi  = r_shift[47];
            end
         end
`endif
         S_LEAD: begin
            if (w_tmr_zero) begin
               w_state = S_LOW;
               w_tmr   = LP_DIV_LD;
            end
         end
         S_LOW: begin
            if (w_tmr_zero) begin
               w_state = S_HIGH;
               w_tmr   = LP_DIV_LD;
               w_sclk  = 1'b1;
            end
         end
         S_HIGH: begin
            if (w_tmr_zero) begin
               w_sclk = 1'b0;
               if (r_bits == 6'd1) begin
                  w_state = S_TRAIL;
                  w_tmr   = LP_GUARD_LD;
               end else begin
                  // Falling edge: present the next bit for a full LOW+HIGH period.
                  w_state = S_LOW;
                  w_tmr   = LP_DIV_LD;
                  w_bits  = r_bits - 6'd1;
                  w_shift = r_shift << 1;
                  w_mosi  = r_shift[46];
               end
            end
         end
         S_TRAIL: begin
            if (w_tmr_zero) begin
               w_state = S_GAP;
               w_tmr   = LP_GUARD_LD;
               w_csb   = 1'b1;
               w_mosi  = 1'b0;
            end
         end
         S_GAP: begin
            if (w_tmr_zero) begin
               w_state = S_IDLE;
               w_done  = 1'b1;
               w_ready = 1'b1;
            end
         end
         default: begin
            w_state = S_IDLE;
            w_csb   = 1'b1;
            w_sclk  = 1'b0;
            w_mosi  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
         r_tmr   <= '0;
         r_bits  <= '0;
         r_shift <= '0;
         r_csb   <= 1'b1;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state;
         r_tmr   <= w_tmr;
         r_bits  <= w_bits;
         r_shift <= w_shift;
         r_csb   <= w_csb;
         r_sclk  <= w_sclk;
         r_mosi  <= w_mosi;
         r_done  <= w_done;
         r_ready <= w_ready;
      end
   end

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: mode-0 slave model plus expected-frame queue, two divider settings.

module tb_spi_reg_master;

   typedef struct packed {
      logic [5:0]  nb;
      logic [47:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        sel = 1'b0;
   logic [5:0]  nbits = '0;
   logic [47:0] data = '0;
   logic        vblank = 1'b0;

   logic a_valid, a_ready, a_csb, a_sclk, a_mosi, a_done;
   logic b_valid, b_ready, b_csb, b_sclk, b_mosi, b_done;
   logic m_valid, m_ready, m_csb, m_sclk, m_mosi, m_done;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   exp_t        exp_q[$];
   logic [47:0] rx = '0;
   int          rx_cnt = 0, high_cnt = 0, low_cnt = 0, glitch = 0;
   int          acc_n = 0, done_cyc = 0, csb_fall = 0, csb_rise = 0, first_rise = 0;
   int          done_cnt = 0, gap_run = 0, min_gap = 1000;
   bit          acc_in_done = 1'b0;
   logic        prev_csb = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

   logic [47:0] trio [3] = '{48'h0000_0000_1111, 48'h0000_0000_C3A5, 48'h0000_0000_0F0F};

   assign a_valid = valid & ~sel;
   assign b_valid = valid & sel;
   assign m_valid = sel ? b_valid : a_valid;
   assign m_ready = sel ? b_ready : a_ready;
   assign m_csb   = sel ? b_csb   : a_csb;
   assign m_sclk  = sel ? b_sclk  : a_sclk;
   assign m_mosi  = sel ? b_mosi  : a_mosi;
   assign m_done  = sel ? b_done  : a_done;

   spi_reg_master u_dut_a (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_valid   (a_valid),
      .o_ready   (a_ready),
      .i_nbits   (nbits),
      .i_data    (data),
      .i_vblank  (vblank),
      .o_csb     (a_csb),
      .o_sclk    (a_sclk),
      .o_mosi    (a_mosi),
      .o_done    (a_done)
   );

   spi_reg_master #(.CLK_DIV(1), .GUARD(2), .MAX_BITS(48)) u_dut_b (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_valid   (b_valid),
      .o_ready   (b_ready),
      .i_nbits   (nbits),
      .i_data    (data),
      .i_vblank  (vblank),
      .o_csb     (b_csb),
      .o_sclk    (b_sclk),
      .o_mosi    (b_mosi),
      .o_done    (b_done)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // Slave model and frame timing monitor; samples on the falling clock edge.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (m_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc + 1;
         chk("ready_with_done", {63'd0, m_ready}, 64'd1);
         chk("sb_nonempty", {63'd0, exp_q.size() > 0}, 64'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rx_bits", 64'(rx_cnt), 64'(e.nb));
            chk("rx_data", 64'(rx), 64'(e.d));
         end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1 && rst_n === 1'b1) begin
         acc_n = cyc + 1;
         acc_in_done = (m_done === 1'b1);
         rx = '0; rx_cnt = 0; high_cnt = 0; low_cnt = 0; glitch = 0;
         csb_fall = 0; csb_rise = 0; first_rise = 0;
      end
      if (m_csb === 1'b0 && prev_csb === 1'b1) begin
         csb_fall = cyc + 1;
         if (gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
         gap_run = 0;
      end
      if (m_csb === 1'b1 && prev_csb === 1'b0) begin
         csb_rise = cyc + 1;
         gap_run = 1;
      end else if (m_csb === 1'b1 && gap_run > 0) begin
         gap_run++;
      end
      if (m_csb === 1'b0) low_cnt++;
      if (m_csb === 1'b0 && m_sclk === 1'b1 && prev_sclk === 1'b0) begin
         rx = {rx[46:0], m_mosi};
         rx_cnt++;
         if (first_rise == 0) first_rise = cyc + 1;
      end
      if (m_sclk === 1'b1) high_cnt++;
      if (m_sclk === 1'b1 && prev_sclk === 1'b1 && m_mosi !== prev_mosi) glitch++;
      prev_csb = m_csb; prev_sclk = m_sclk; prev_mosi = m_mosi;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int nb, input logic [47:0] d);
      exp_t e;
      int   nbc;
      nbc  = (nb > 48) ? 48 : nb;
      e.nb = 6'(nbc);
      e.d  = d & ((48'h1 << nbc) - 48'h1);
      valid = 1'b1;
      nbits = 6'(nb);
      data  = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_accept();
      bit ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (m_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("accept", {63'd0, ok}, 64'd1);
      if (ok) tick();
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      int start = done_cnt;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (done_cnt != start) begin
            ok = 1'b1;
            break;
         end
      end
      chk("done_seen", {63'd0, ok}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=%0d expected=<200000", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int   start;
      int   rises;
      logic ps;

      // Reset state
      repeat (3) tick();
      chk("rst_ready", {63'd0, a_ready}, 64'd0);
      chk("rst_csb",   {63'd0, a_csb},   64'd1);
      chk("rst_sclk",  {63'd0, a_sclk},  64'd0);
      chk("rst_mosi",  {63'd0, a_mosi},  64'd0);
      chk("rst_done",  {63'd0, a_done},  64'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // 8-bit 0xA5 with default timing; vblank held low and ignored
      drive(8, 48'hA5);
      wait_accept();
      valid = 1'b0;
      wait_done();
      chk("a5_single_done", {63'd0, a_done}, 64'd0);
      chk("a5_csb_fall",  64'(csb_fall - acc_n),   64'd1);
      chk("a5_first_rise", 64'(first_rise - acc_n), 64'd5);
      chk("a5_csb_rise",  64'(csb_rise - acc_n),   64'd37);
      chk("a5_done_cyc",  64'(done_cyc - acc_n),   64'd39);
      chk("a5_csb_low",   64'(low_cnt),            64'd36);
      chk("a5_glitch",    64'(glitch),             64'd0);

      // nbits = 0: no CSB activity, done after GUARD+1
      drive(0, 48'hFFFF_FFFF_FFFF);
      wait_accept();
      valid = 1'b0;
      wait_done();
      chk("nb0_no_csb",   64'(csb_fall),          64'd0);
      chk("nb0_done_cyc", 64'(done_cyc - acc_n),  64'd3);

      // nbits = 60 clamps to 48
      drive(60, 48'h9A5F_3C1E_77D2);
      wait_accept();
      valid = 1'b0;
      wait_done();
      chk("nb60_done_cyc", 64'(done_cyc - acc_n), 64'd1 + 64'd6 + 64'd192);

      // Three frames with valid held; data changes while each is in flight
      min_gap = 1000;
      start = done_cnt;
      drive(16, trio[0]);
      for (int i = 0; i < 3; i++) begin
         wait_accept();
         if (i > 0) chk("b2b_accept_in_done", {63'd0, acc_in_done}, 64'd1);
         if (i < 2) drive(16, trio[i + 1]);
         else begin
            data  = 48'hFFFF_FFFF_FFFF;
            valid = 1'b0;
         end
      end
      wait_done();
      chk("b2b_done_count", 64'(done_cnt - start), 64'd3);
      chk("b2b_min_gap",    64'(min_gap),          64'd3);

      // Reset during the third SCLK high phase of a 16-bit frame
      drive(16, 48'hBEEF);
      wait_accept();
      valid = 1'b0;
      rises = 0;
      ps = a_sclk;
      for (int k = 0; k < 200 && rises < 3; k++) begin
         tick();
         if (a_sclk === 1'b1 && ps === 1'b0) rises++;
         ps = a_sclk;
      end
      chk("mid_rst_reached_hi3", 64'(rises), 64'd3);
      chk("mid_rst_mosi_before", {63'd0, a_mosi}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready_low", {63'd0, a_ready}, 64'd0);
      tick();
      rst_n = 1'b1;
      chk("mid_rst_csb",   {63'd0, a_csb},   64'd1);
      chk("mid_rst_sclk",  {63'd0, a_sclk},  64'd0);
      chk("mid_rst_mosi",  {63'd0, a_mosi},  64'd0);
      chk("mid_rst_ready", {63'd0, a_ready}, 64'd0);
      start = done_cnt;
      repeat (60) tick();
      chk("mid_rst_no_done", 64'(done_cnt - start), 64'd0);
      void'(exp_q.pop_back());
      drive(16, 48'h5A5A);
      wait_accept();
      valid = 1'b0;
      wait_done();
      chk("after_rst_done_cyc", 64'(done_cyc - acc_n), 64'd71);

      // CLK_DIV = 1, full 48-bit frame on the second instance
      sel = 1'b1;
      tick();
      drive(48, 48'h1234_5678_9ABC);
      wait_accept();
      valid = 1'b0;
      wait_done();
      chk("div1_high_cycles", 64'(high_cnt),            64'd48);
      chk("div1_csb_low",     64'(low_cnt),             64'd100);
      chk("div1_glitch",      64'(glitch),              64'd0);
      chk("div1_first_rise",  64'(first_rise - acc_n),  64'd4);
      chk("div1_csb_rise",    64'(csb_rise - acc_n),    64'd101);
      chk("sb_drained",       64'(exp_q.size()),        64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
